// File: rtl/clk_en_seq.sv
// Lock sequencer and phase-aligned clock-enable generator behind the PLL.
// Latency: lock seen 2+LOCK_FILTER+RST_HOLD cycles after pll_locked; loss seen after 2 cycles.
// Backpressure: none; cfg_load/clear are single-cycle strobes and are always accepted.
module clk_en_seq #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int LOCK_FILTER = 16,
    parameter int RST_HOLD    = 32,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pll_locked,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic [NUM_CH*DIV_W-1:0] phase_cfg,
    input  logic                    cfg_load,
    input  logic                    clear,
    output logic                    rst_out,
    output logic                    ready,
    output logic [NUM_CH-1:0]       ce,
    output logic                    lock_lost,
    output logic [CNT_W-1:0]        lock_lost_cnt
);

    localparam int SEQ_MAX = (LOCK_FILTER > RST_HOLD) ? LOCK_FILTER : RST_HOLD;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_FILT = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t                         state_q, state_nxt;
    logic [SEQ_W-1:0]               seq_q, seq_nxt;
    logic                           sync_q1, lk;
    logic [NUM_CH*DIV_W-1:0]        div_sh, ph_sh;
    logic [NUM_CH-1:0][DIV_W-1:0]   cnt_q, cnt_nxt;
    logic [NUM_CH-1:0][DIV_W-1:0]   d_new, p_new, d_cur, start;
    logic [NUM_CH-1:0]              ce_nxt;
    logic                           load_en;
    logic                           rst_nxt, ready_nxt;
    logic                           lost_evt, lost_nxt;
    logic [CNT_W-1:0]               cnt_base, lost_cnt_nxt;

    // Two-flop synchroniser; only lk feeds the sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            lk      <= 1'b0;
        end else begin
            sync_q1 <= pll_locked;
            lk      <= sync_q1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_WAIT;
            seq_q         <= '0;
            cnt_q         <= '0;
            div_sh        <= '0;
            ph_sh         <= '0;
            rst_out       <= 1'b1;
            ready         <= 1'b0;
            ce            <= '0;
            lock_lost     <= 1'b0;
            lock_lost_cnt <= '0;
        end else begin
            state_q       <= state_nxt;
            seq_q         <= seq_nxt;
            cnt_q         <= cnt_nxt;
            rst_out       <= rst_nxt;
            ready         <= ready_nxt;
            ce            <= ce_nxt;
            lock_lost     <= lost_nxt;
            lock_lost_cnt <= lost_cnt_nxt;
            if (cfg_load) begin
                div_sh <= div_cfg;
                ph_sh  <= phase_cfg;
            end
        end
    end

    // Next-state: FILTER leaves once the count has already reached LOCK_FILTER,
    // HOLD leaves on the cycle its count would reach RST_HOLD.
    always_comb begin
        state_nxt = state_q;
        seq_nxt   = seq_q;
        case (state_q)
            S_WAIT: begin
                if (lk) begin
                    state_nxt = S_FILT;
                    seq_nxt   = SEQ_W'(1);
                end
            end
            S_FILT: begin
                if (!lk) begin
                    state_nxt = S_WAIT;
                    seq_nxt   = '0;
                end else if (seq_q == SEQ_W'(LOCK_FILTER)) begin
                    state_nxt = S_HOLD;
                    seq_nxt   = '0;
                end else begin
                    seq_nxt = seq_q + SEQ_W'(1);
                end
            end
            S_HOLD: begin
                if (!lk) begin
                    state_nxt = S_WAIT;
                    seq_nxt   = '0;
                end else if (seq_q == SEQ_W'(RST_HOLD - 1)) begin
                    state_nxt = S_RUN;
                    seq_nxt   = '0;
                end else begin
                    seq_nxt = seq_q + SEQ_W'(1);
                end
            end
            default: begin
                if (!lk) begin
                    state_nxt = S_WAIT;
                    seq_nxt   = '0;
                end
            end
        endcase
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        rst_nxt   = (state_nxt != S_RUN);
        ready_nxt = (state_nxt == S_RUN);
        lost_evt  = (state_q == S_RUN) && !lk;

        lost_nxt     = clear ? 1'b0 : lock_lost;
        cnt_base     = clear ? '0 : lock_lost_cnt;
        lost_cnt_nxt = cnt_base;
        if (lost_evt) begin
            lost_nxt = 1'b1;
            if (cnt_base != {CNT_W{1'b1}})
                lost_cnt_nxt = cnt_base + CNT_W'(1);
        end

        // All channels reload together so their phases stay aligned.
        load_en = (state_nxt == S_RUN) && ((state_q != S_RUN) || cfg_load);
        for (int i = 0; i < NUM_CH; i++) begin
            d_cur[i] = div_sh[i*DIV_W +: DIV_W];
            d_new[i] = cfg_load ? div_cfg[i*DIV_W +: DIV_W]   : div_sh[i*DIV_W +: DIV_W];
            p_new[i] = cfg_load ? phase_cfg[i*DIV_W +: DIV_W] : ph_sh[i*DIV_W +: DIV_W];
            start[i] = (p_new[i] > d_new[i]) ? d_new[i] : p_new[i];
            if (load_en)
                cnt_nxt[i] = start[i];
            else if (state_q == S_RUN)
                cnt_nxt[i] = (cnt_q[i] == d_cur[i]) ? '0 : cnt_q[i] + DIV_W'(1);
            else
                cnt_nxt[i] = '0;
            ce_nxt[i] = (state_nxt == S_RUN) && (cnt_nxt[i] == d_new[i]);
        end
    end

endmodule

// File: tb/tb_clk_en_seq.sv
// Randomised bench for clk_en_seq against a streak/modulo reference model.
module tb_clk_en_seq;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;
    localparam int LF     = 4;
    localparam int RH     = 8;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    reset, pll_locked, cfg_load, clear;
    logic [NUM_CH*DIV_W-1:0] div_cfg, phase_cfg;
    logic                    rst_out, ready, lock_lost;
    logic [NUM_CH-1:0]       ce;
    logic [CNT_W-1:0]        lock_lost_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int                st1, st2, n_run, cnt_m;
    bit                ready_m, lost_m;
    int                sh_d [NUM_CH];
    int                sh_p [NUM_CH];
    int                ep_d [NUM_CH];
    int                ep_s [NUM_CH];
    logic [NUM_CH-1:0] ce_m;

    logic [11:0] pat     [NUM_CH];
    logic [11:0] pat_exp [NUM_CH] = '{12'hFFF, 12'h888, 12'h222, 12'h421};

    clk_en_seq #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_FILTER(LF), .RST_HOLD(RH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .pll_locked(pll_locked),
        .div_cfg(div_cfg), .phase_cfg(phase_cfg), .cfg_load(cfg_load), .clear(clear),
        .rst_out(rst_out), .ready(ready), .ce(ce),
        .lock_lost(lock_lost), .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ready is 1 once the run of consecutive high pll samples ending two edges
    // ago spans LF+RH+1 samples; strobes follow (start+n) mod (D+1) == D.
    task automatic model_edge();
        bit rdy_prev;
        bit load_in_run;
        rdy_prev = ready_m;
        if (reset) begin
            st1 = 0; st2 = 0; ready_m = 0; lost_m = 0; cnt_m = 0; n_run = 0; ce_m = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                sh_d[i] = 0; sh_p[i] = 0;
            end
        end else begin
            load_in_run = cfg_load && rdy_prev;
            if (cfg_load) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    sh_d[i] = int'(div_cfg[i*DIV_W +: DIV_W]);
                    sh_p[i] = int'(phase_cfg[i*DIV_W +: DIV_W]);
                end
            end
            ready_m = (st2 >= LF + RH + 1);
            st2 = st1;
            st1 = pll_locked ? ((st1 < 1000) ? st1 + 1 : st1) : 0;
            if (clear) begin
                lost_m = 0; cnt_m = 0;
            end
            if (rdy_prev && !ready_m) begin
                lost_m = 1;
                if (cnt_m < CMAX) cnt_m++;
            end
            if (ready_m && (!rdy_prev || load_in_run)) begin
                n_run = 0;
                for (int i = 0; i < NUM_CH; i++) begin
                    ep_d[i] = sh_d[i];
                    ep_s[i] = (sh_p[i] > sh_d[i]) ? sh_d[i] : sh_p[i];
                end
            end
            ce_m = '0;
            if (ready_m) begin
                for (int i = 0; i < NUM_CH; i++)
                    ce_m[i] = (((ep_s[i] + n_run) % (ep_d[i] + 1)) == ep_d[i]);
                n_run++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("ready",   32'(ready),         32'(ready_m));
        chk("rst_out", 32'(rst_out),       32'(!ready_m));
        chk("ce",      32'(ce),            32'(ce_m));
        chk("lost",    32'(lock_lost),     32'(lost_m));
        chk("lostcnt", 32'(lock_lost_cnt), 32'(cnt_m));
    endtask

    task automatic set_cfg(input int ch, input int d, input int p);
        div_cfg[ch*DIV_W +: DIV_W]   = DIV_W'(d);
        phase_cfg[ch*DIV_W +: DIV_W] = DIV_W'(p);
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 100; k++) begin
            tick();
            if (ready) return;
        end
        chk("wait_ready_timeout", 32'd0, 32'd1);
    endtask

    // Drops lock for one cycle while in RUN; optional clear on the loss edge.
    task automatic drop_lock(input bit with_clear);
        wait_ready();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        chk("loss_rst_early", 32'(rst_out), 32'd0);
        clear = with_clear;
        tick();
        chk("loss_rst_2cyc", 32'(rst_out), 32'd1);
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pll_locked = 1'b0; cfg_load = 1'b0; clear = 1'b0;
        div_cfg = '0; phase_cfg = '0;
        st1 = 0; st2 = 0; n_run = 0; cnt_m = 0; ready_m = 0; lost_m = 0; ce_m = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sh_d[i] = 0; sh_p[i] = 0; ep_d[i] = 0; ep_s[i] = 0; pat[i] = '0;
        end

        repeat (3) tick();
        chk("reset_rst_out", 32'(rst_out), 32'd1);
        chk("reset_ce",      32'(ce),      32'd0);

        // Power-up with the divider table loaded while still locked out
        reset = 1'b0;
        set_cfg(0, 0, 0); set_cfg(1, 3, 0); set_cfg(2, 3, 2); set_cfg(3, 4, 9);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        repeat (5) tick();
        pll_locked = 1'b1;
        repeat (14) tick();
        chk("pwr_not_ready", 32'(ready),   32'd0);
        chk("pwr_in_reset",  32'(rst_out), 32'd1);
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 0) chk("pwr_ready_at_14", 32'(ready), 32'd1);
            for (int c = 0; c < NUM_CH; c++) pat[c][k] = ce[c];
        end
        for (int c = 0; c < NUM_CH; c++) chk($sformatf("div_pattern_ch%0d", c), 32'(pat[c]), 32'(pat_exp[c]));
        chk("pwr_no_loss", 32'(lock_lost), 32'd0);

        // Live reconfig of ch1 to D=1 P=1
        set_cfg(1, 1, 1);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        chk("reconf_ch1_a", 32'(ce[1]), 32'd1);
        tick();
        chk("reconf_ch1_b", 32'(ce[1]), 32'd0);
        tick();
        chk("reconf_ch1_c", 32'(ce[1]), 32'd1);

        // Loss accounting, clear coincident with a loss, then saturation
        repeat (3) drop_lock(1'b0);
        chk("loss3_flag", 32'(lock_lost),     32'd1);
        chk("loss3_cnt",  32'(lock_lost_cnt), 32'd3);
        drop_lock(1'b1);
        chk("clear_loss_flag", 32'(lock_lost),     32'd1);
        chk("clear_loss_cnt",  32'(lock_lost_cnt), 32'd1);
        repeat (3) drop_lock(1'b0);
        chk("loss_saturate", 32'(lock_lost_cnt), 32'(CMAX));

        // Synchronous reset from RUN
        wait_ready();
        reset = 1'b1;
        tick();
        chk("rst_run_rst_out", 32'(rst_out),       32'd1);
        chk("rst_run_ce",      32'(ce),            32'd0);
        chk("rst_run_cnt",     32'(lock_lost_cnt), 32'd0);
        reset = 1'b0;
        wait_ready();
        chk("rst_shadow_zero", 32'(ce),        32'hF);
        chk("rst_not_loss",    32'(lock_lost), 32'd0);

        // One-cycle glitch two cycles into FILTER restarts the whole sequence
        reset = 1'b1; pll_locked = 1'b0;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        pll_locked = 1'b1;
        repeat (4) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        repeat (14) tick();
        chk("glitch_not_ready", 32'(ready), 32'd0);
        tick();
        chk("glitch_ready",     32'(ready),         32'd1);
        chk("glitch_no_count",  32'(lock_lost_cnt), 32'd0);

        // Random soak
        for (int it = 0; it < 3000; it++) begin
            if (pll_locked) begin
                if ($urandom_range(0, 59) == 0) pll_locked = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                pll_locked = 1'b1;
            end
            cfg_load = ($urandom_range(0, 24) == 0);
            if (cfg_load)
                for (int c = 0; c < NUM_CH; c++)
                    set_cfg(c, int'($urandom_range(0, 7)), int'($urandom_range(0, 9)));
            clear = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0; cfg_load = 1'b0; clear = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_en_seq.md
Name: clk_en_seq

Overview:
- Parametrised lock-sequencing and clock-enable generator that sits directly behind the ECP5 EHXPLLL instance, in the PLL output clock domain.
- Filters the PLL lock signal, sequences a held reset for the downstream design, and produces NUM_CH programmable, phase-offset clock-enable strobes.
- Reports loss-of-lock events.
- Replaces fixed-frequency derived clocks: logic runs on one PLL clock and uses the ce strobes for lower rates.

Parameters:
- NUM_CH, 4: number of clock-enable channels (1..16).
- DIV_W, 8: width of each channel's divider and phase field.
- LOCK_FILTER, 16: consecutive synchronised-lock-high cycles required before leaving FILTER (>=2).
- RST_HOLD, 32: cycles rst_out is held in HOLD after the filter passes (>=1).
- CNT_W, 8: width of the loss-of-lock event counter.

Ports:
- clk  in  1  PLL output clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- pll_locked  in  1  raw PLL LOCK, asynchronous to clk.
- div_cfg  in  NUM_CH*DIV_W  per-channel divider D; channel i uses bits [i*DIV_W +: DIV_W]; period = D+1 cycles.
- phase_cfg  in  NUM_CH*DIV_W  per-channel phase P, same packing.
- cfg_load  in  1  one-cycle strobe: capture div_cfg/phase_cfg into shadow registers.
- clear  in  1  clears lock_lost and lock_lost_cnt.
- rst_out  out  1  active-high reset for downstream logic.
- ready  out  1  high only in RUN.
- ce  out  NUM_CH  per-channel one-cycle clock-enable strobes.
- lock_lost  out  1  sticky flag: lock dropped while in RUN.
- lock_lost_cnt  out  CNT_W  saturating count of RUN-state lock losses.

Behaviour:
- **Reset values:**
  - reset=1 at a clk edge: state=WAIT_LOCK; synchroniser flops=0; all counters=0; shadow D=0 and P=0.
  - Outputs: rst_out=1, ready=0, ce=0, lock_lost=0, lock_lost_cnt=0.
  - reset mid-operation behaves identically, including from RUN; it does not count as a lock loss.
- **Lock synchroniser:** pll_locked passes through a 2-flop synchroniser; its output is lk. All FSM decisions use lk only.
- **FSM, all outputs registered:**
  - WAIT_LOCK: lk=1 -> FILTER with filter count=1.
  - FILTER: lk=0 -> WAIT_LOCK. Otherwise increment the count; when count reaches LOCK_FILTER -> HOLD with hold count=0.
  - HOLD: lk=0 -> WAIT_LOCK. Otherwise increment the count; when it reaches RST_HOLD -> RUN.
  - RUN: lk=0 -> WAIT_LOCK, and lock_lost and lock_lost_cnt update as below.
- **Outputs by state:**
  - rst_out=1 in every state except RUN.
  - ready=1 only in RUN.
  - ce=0 outside RUN.
- **Timing:**
  - With pll_locked held high, ready and the deassertion of rst_out occur exactly 2+LOCK_FILTER+RST_HOLD cycles after the first clk edge sampling pll_locked=1.
  - Both rise on the same edge.
  - On loss of lock, rst_out rises and ready falls 2 cycles after pll_locked falls.
- **Clock enables:**
  - Each channel has an internal counter c.
  - On RUN entry, and on cfg_load while in RUN, all channels load c=min(P,D) in the same cycle (aligned phase).
  - In RUN, each cycle: if c==D then ce[i]=1 and c<=0, else ce[i]=0 and c<=c+1.
  - D=0 gives ce[i]=1 every RUN cycle.
  - The first strobe comes D-min(P,D) cycles after load; strobes then repeat every D+1 cycles.
  - P>D is clamped to D, giving a strobe on the first RUN cycle.
- **cfg_load outside RUN:** updates the shadow registers only; counters load on RUN entry.
- **cfg_load in RUN:** the load cycle's ce is computed from the old counters; the new values apply from the next cycle.
- **Loss accounting:**
  - A RUN->WAIT_LOCK transition sets lock_lost=1 and increments lock_lost_cnt, saturating at 2^CNT_W-1.
  - Lock drops in FILTER or HOLD are not counted.
  - If clear and a loss occur in the same cycle: clear first, then increment, so lock_lost=1 and lock_lost_cnt=1.
- **Glitches:** a one-cycle lk glitch low in FILTER or HOLD restarts the full sequence from WAIT_LOCK.

Test Plan:
- Power-up sequencing: LOCK_FILTER=4, RST_HOLD=8, pll_locked rises at cycle 10 and stays high -> rst_out=1 and ready=0 until cycle 24; ready=1 and rst_out=0 from cycle 24; lock_lost=0.
- Lock glitch in FILTER: drop pll_locked for 1 cycle after 2 filter cycles -> FSM returns to WAIT_LOCK; ready delayed by the full 14 cycles after relock; lock_lost_cnt=0.
- Dividers: ch0 D=0 P=0; ch1 D=3 P=0; ch2 D=3 P=2; ch3 D=4 P=9 (clamped) -> in RUN:
  - ch0 strobes every cycle.
  - ch1 strobes on RUN cycles 3, 7, 11.
  - ch2 strobes on RUN cycles 1, 5, 9.
  - ch3 strobes on RUN cycles 0, 5, 10.
- Live reconfig: in RUN, cfg_load with ch1 D=1 P=1 -> ch1 strobes on the cycle after the load, then every 2 cycles; the other channels realign to their phase.
- Loss accounting: drop pll_locked 3 times in RUN with relock between -> lock_lost=1, lock_lost_cnt=3, rst_out=1 two cycles after each drop. Then assert clear in the same cycle as a 4th loss -> lock_lost_cnt=1.
- Synchronous reset in RUN -> next cycle state=WAIT_LOCK, rst_out=1, ce=0, lock_lost_cnt=0, shadow config D=0/P=0.
